ws2812_chain: RTL



---
 rtl/ws2812_chain.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ws2812_chain.sv
// ws2812_chain: drives a daisy-chain of NUM_LEDS WS2812 pixels from an internal
// colour register file. A one-cycle `update` strobe sends the whole chain with
// exact bit timing and then holds the line low for the latch gap.
//
// Ports:
//   clk        system clock (CLK_MHZ MHz)
//   reset      synchronous, active-high
//   wr_en      pixel write strobe
//   wr_addr    pixel index; writes at or beyond NUM_LEDS are dropped
//   wr_data    colour {R[23:16], G[15:8], B[7:0]}
//   update     frame request; if it arrives while busy, it is queued once
//   brightness global 0..255 scale, only when WS2812_BRIGHTNESS_EN is defined
//   busy       a frame or its latch gap is in progress
//   ws2812     serial line to the first pixel
//
// Optional feature macro: WS2812_BRIGHTNESS_EN.
module ws2812_chain #(
    parameter int NUM_LEDS = 1,
    parameter int CLK_MHZ  = 27,
    parameter int RST_US   = 80,
    parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              update,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]        brightness,
`endif
    output logic              busy,
    output logic              ws2812
);

    localparam int BIT_CYC = CLK_MHZ * 1250 / 1000;
    localparam int T0H     = CLK_MHZ * 350 / 1000;
    localparam int T1H     = CLK_MHZ * 700 / 1000;
    localparam int RST_CYC = CLK_MHZ * RST_US;
    localparam int CNT_W   = $clog2(RST_CYC + BIT_CYC + 1);

    // Counters hold "cycles left minus one" for the current phase.
    localparam logic [CNT_W-1:0] H0  = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] H1  = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] L0  = CNT_W'(BIT_CYC - T0H - 1);
    localparam logic [CNT_W-1:0] L1  = CNT_W'(BIT_CYC - T1H - 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(RST_CYC - 1);

    localparam logic [ADDR_W:0]   NUM_L = (ADDR_W + 1)'(NUM_LEDS);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_LEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_LATCH
    } state_t;

    logic [23:0]       ram [NUM_LEDS];
    state_t            state;
    logic              pending;
    logic [23:0]       shift;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-1:0] pix;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] fetch_addr;
    logic [23:0]       raw;
    logic [23:0]       fetch_grb;

`ifdef WS2812_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c,
                                         input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, c} * ({8'd0, b} + 16'd1);
        return p[15:8];
    endfunction
`endif

    // Pixel store: no reset, writes accepted in every state.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < NUM_L))
            ram[wr_addr] <= wr_data;
    end

    // Fetch port: pixel 0 during LOAD, otherwise the pixel after the one
    // being shifted. It is consumed on the edge that ends the last bit of
    // the current pixel, so the next pixel follows with no gap.
    always_comb begin
        fetch_addr = (state == S_LOAD) ? '0 : pix + 1'b1;
        raw = '0;
        if ({1'b0, fetch_addr} < NUM_L)
            raw = ram[fetch_addr];
`ifdef WS2812_BRIGHTNESS_EN
        fetch_grb = {scale(raw[15:8], brightness),
                     scale(raw[23:16], brightness),
                     scale(raw[7:0], brightness)};
`else
        fetch_grb = {raw[15:8], raw[23:16], raw[7:0]};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            ws2812  <= 1'b0;
            pending <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
            pix     <= '0;
            cnt     <= '0;
        end else begin
            if (update && state != S_IDLE)
                pending <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (update || pending) begin
                        state   <= S_LOAD;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                S_LOAD: begin
                    shift   <= fetch_grb;
                    bit_cnt <= '0;
                    pix     <= '0;
                    ws2812  <= 1'b1;
                    cnt     <= fetch_grb[23] ? H1 : H0;
                    state   <= S_HIGH;
                end
                S_HIGH: begin
                    if (cnt == '0) begin
                        ws2812 <= 1'b0;
                        cnt    <= shift[23] ? L1 : L0;
                        state  <= S_LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (bit_cnt == 5'd23 && pix == LAST) begin
                        cnt   <= LAT;
                        state <= S_LATCH;
                    end else begin
                        ws2812 <= 1'b1;
                        state  <= S_HIGH;
                        if (bit_cnt == 5'd23) begin
                            shift   <= fetch_grb;
                            bit_cnt <= '0;
                            pix     <= pix + 1'b1;
                            cnt     <= fetch_grb[23] ? H1 : H0;
                        end else begin
                            shift   <= {shift[22:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                            cnt     <= shift[22] ? H1 : H0;
                        end
                    end
                end
                S_LATCH: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
